// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer.
// in_ready is driven from the skid valid bit only, so MEM back-pressure never reaches EX combinationally.
module ex_mem_pipe_stage #(
   parameter int DATA_W       = 32,
   parameter int RA_W         = 5,
   parameter bit ZERO_RD_NOWB = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_rdata,
   input  logic [RA_W-1:0]   in_rd,
   input  logic              in_regwrite,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_mem_rdata,
   output logic [RA_W-1:0]   out_rd,
   output logic              out_regwrite,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rdata;
      logic [RA_W-1:0]   rd;
      logic              we;
   } ent_t;

   ent_t main_q, main_d, skid_q, skid_d, cap;
   logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic accept, pop;

   assign in_ready = !rst && !skid_vld_q;
   assign accept   = in_valid && in_ready;
   assign pop      = main_vld_q && out_ready;

   // Writes to x0 are architecturally discarded, so drop the enable at capture.
   always_comb begin
      cap.alu   = in_alu_result;
      cap.rdata = in_mem_rdata;
      cap.rd    = in_rd;
      cap.we    = in_regwrite && !(ZERO_RD_NOWB && (in_rd == '0));
   end

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q) begin
         if (accept) begin
            main_d     = cap;
            main_vld_d = 1'b1;
         end
      end else if (pop) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d = cap;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = cap;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign out_valid      = main_vld_q;
   assign out_alu_result = main_q.alu;
   assign out_mem_rdata  = main_q.rdata;
   assign out_rd         = main_q.rd;
   assign out_regwrite   = main_q.we && main_vld_q;
   assign occupancy      = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule
